// File: rtl/onewire_bus_if.sv
// Command/response and pad-level signals of the 1-wire bus master.
// master: the bus master block; slave: the host register decoder and pads.
// ONEWIRE_STRONG_PULLUP_EN adds cmdStrongPullup and strongPullup.
interface onewire_bus_if #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned CHANNEL_BITS = 1
);
    logic                    cmdValid;
    logic                    cmdReady;
    logic [1:0]              cmdOp;
    logic [CHANNEL_BITS-1:0] cmdChannel;
    logic [7:0]              cmdData;
    logic                    rspValid;
    logic [7:0]              rspData;
    logic                    rspPresence;
    logic                    rspError;
    logic [CHANNELS-1:0]     busIn;
    logic [CHANNELS-1:0]     busOut;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic                    cmdStrongPullup;
    logic [CHANNELS-1:0]     strongPullup;

    modport master (
        input  cmdValid, cmdOp, cmdChannel, cmdData, cmdStrongPullup, busIn,
        output cmdReady, rspValid, rspData, rspPresence, rspError, busOut, strongPullup
    );
    modport slave (
        output cmdValid, cmdOp, cmdChannel, cmdData, cmdStrongPullup, busIn,
        input  cmdReady, rspValid, rspData, rspPresence, rspError, busOut, strongPullup
    );
`else
    modport master (
        input  cmdValid, cmdOp, cmdChannel, cmdData, busIn,
        output cmdReady, rspValid, rspData, rspPresence, rspError, busOut
    );
    modport slave (
        output cmdValid, cmdOp, cmdChannel, cmdData, busIn,
        input  cmdReady, rspValid, rspData, rspPresence, rspError, busOut
    );
`endif
endinterface

// File: rtl/onewire_bus_master.sv
// Multi-channel 1-wire bus master: hardware reset/presence and read/write time slots.
// Ports:
//   clock, nReset : system clock, asynchronous active-low reset
//   bus (master)  : cmdValid/cmdReady/cmdOp/cmdChannel/cmdData command handshake,
//                   rspValid/rspData/rspPresence/rspError response,
//                   busIn (raw line levels), busOut (1 = pull line low)
// Option macro ONEWIRE_STRONG_PULLUP_EN: adds cmdStrongPullup/strongPullup, which
// enables a strong pullup on the channel after a BYTE until the next accept.
module onewire_bus_master #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned CHANNEL_BITS = 1,
    parameter int unsigned TICK_DIV     = 29
) (
    input  logic          clock,
    input  logic          nReset,
    onewire_bus_if.master bus
);
    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMR_W = 10;

    localparam logic [TMR_W-1:0] T_RST_REL  = TMR_W'(480);
    localparam logic [TMR_W-1:0] T_RST_SAMP = TMR_W'(550);
    localparam logic [TMR_W-1:0] T_RST_END  = TMR_W'(960);
    localparam logic [TMR_W-1:0] T_REL_ONE  = TMR_W'(6);
    localparam logic [TMR_W-1:0] T_REL_ZERO = TMR_W'(60);
    localparam logic [TMR_W-1:0] T_SAMP     = TMR_W'(15);
    localparam logic [TMR_W-1:0] T_SLOT_END = TMR_W'(70);

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_BYTE  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LOW, S_RST_WAIT, S_RST_RECOVER,
        S_SLOT_LOW, S_SLOT_WAIT, S_SLOT_RECOVER, S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [CHANNEL_BITS-1:0] ch_q, ch_d;
    logic [7:0]              data_q, data_d;
    logic [7:0]              samp_q, samp_d;
    logic [2:0]              bit_idx_q, bit_idx_d;
    logic                    is_byte_q, is_byte_d;
    logic                    presence_q, presence_d;
    logic                    err_q, err_d;
    logic                    drive_q, drive_d;
    logic                    ready_q, ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_data_q, rsp_data_d;
    logic                    rsp_presence_q, rsp_presence_d;
    logic                    rsp_error_q, rsp_error_d;
    logic [CHANNELS-1:0]     bus_out_q, bus_out_d;
    logic [CHANNELS-1:0]     sync1_q, sync2_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    logic                    spu_req_q, spu_req_d;
    logic [CHANNELS-1:0]     spu_q, spu_d;
`endif

    logic             tick;
    logic [TMR_W-1:0] t_next;
    logic             accept;
    logic             cmd_err;
    logic             line;
    logic             cur_bit;
    logic             last_bit;

    assign tick     = (pre_q == PRE_W'(TICK_DIV - 1));
    assign t_next   = timer_q + TMR_W'(1);
    assign accept   = bus.cmdValid & ready_q;
    assign cmd_err  = (bus.cmdOp == OP_RSVD) || (32'(bus.cmdChannel) >= CHANNELS);
    assign line     = sync2_q[ch_q];
    assign cur_bit  = data_q[bit_idx_q];
    assign last_bit = (bit_idx_q == (is_byte_q ? 3'd7 : 3'd0));

    // Next-state and datapath: all times are tick counts from reset/slot start.
    always_comb begin
        state_d        = state_q;
        pre_d          = tick ? '0 : pre_q + PRE_W'(1);
        timer_d        = tick ? t_next : timer_q;
        ch_d           = ch_q;
        data_d         = data_q;
        samp_d         = samp_q;
        bit_idx_d      = bit_idx_q;
        is_byte_d      = is_byte_q;
        presence_d     = presence_q;
        err_d          = err_q;
        drive_d        = drive_q;
        ready_d        = ready_q;
        rsp_valid_d    = 1'b0;
        rsp_data_d     = rsp_data_q;
        rsp_presence_d = rsp_presence_q;
        rsp_error_d    = rsp_error_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        spu_req_d      = spu_req_q;
        spu_d          = spu_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d    = 1'b0;
                    pre_d      = '0;
                    timer_d    = '0;
                    ch_d       = bus.cmdChannel;
                    data_d     = bus.cmdData;
                    samp_d     = '0;
                    bit_idx_d  = '0;
                    is_byte_d  = (bus.cmdOp == OP_BYTE);
                    presence_d = 1'b0;
                    err_d      = cmd_err;
`ifdef ONEWIRE_STRONG_PULLUP_EN
                    spu_req_d  = bus.cmdStrongPullup;
                    spu_d      = '0;
`endif
                    if (cmd_err) begin
                        state_d = S_DONE;
                    end else begin
                        drive_d = 1'b1;
                        state_d = (bus.cmdOp == OP_RESET) ? S_RST_LOW : S_SLOT_LOW;
                    end
                end
            end
            S_RST_LOW: begin
                if (tick && t_next == T_RST_REL) begin
                    drive_d = 1'b0;
                    state_d = S_RST_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (tick && t_next == T_RST_SAMP) begin
                    presence_d = ~line;
                    state_d    = S_RST_RECOVER;
                end
            end
            S_RST_RECOVER: begin
                if (tick && t_next == T_RST_END) state_d = S_DONE;
            end
            S_SLOT_LOW: begin
                // A written 0 keeps the line low past the sample point.
                if (tick && t_next == T_SAMP) samp_d[bit_idx_q] = line;
                if (tick && t_next == (cur_bit ? T_REL_ONE : T_REL_ZERO)) begin
                    drive_d = 1'b0;
                    state_d = cur_bit ? S_SLOT_WAIT : S_SLOT_RECOVER;
                end
            end
            S_SLOT_WAIT: begin
                if (tick && t_next == T_SAMP) begin
                    samp_d[bit_idx_q] = line;
                    state_d           = S_SLOT_RECOVER;
                end
            end
            S_SLOT_RECOVER: begin
                if (tick && t_next == T_SLOT_END) begin
                    if (last_bit) begin
                        state_d = S_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        timer_d   = '0;
                        drive_d   = 1'b1;
                        state_d   = S_SLOT_LOW;
                    end
                end
            end
            S_DONE: begin
                rsp_valid_d    = 1'b1;
                rsp_data_d     = samp_q;
                rsp_presence_d = presence_q;
                rsp_error_d    = err_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
                if (is_byte_q && spu_req_q && !err_q) spu_d = CHANNELS'(1) << ch_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        bus_out_d = drive_d ? (CHANNELS'(1) << ch_d) : '0;
    end

    // State and output registers.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q        <= S_IDLE;
            pre_q          <= '0;
            timer_q        <= '0;
            ch_q           <= '0;
            data_q         <= '0;
            samp_q         <= '0;
            bit_idx_q      <= '0;
            is_byte_q      <= 1'b0;
            presence_q     <= 1'b0;
            err_q          <= 1'b0;
            drive_q        <= 1'b0;
            ready_q        <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_presence_q <= 1'b0;
            rsp_error_q    <= 1'b0;
            bus_out_q      <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            spu_req_q      <= 1'b0;
            spu_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            pre_q          <= pre_d;
            timer_q        <= timer_d;
            ch_q           <= ch_d;
            data_q         <= data_d;
            samp_q         <= samp_d;
            bit_idx_q      <= bit_idx_d;
            is_byte_q      <= is_byte_d;
            presence_q     <= presence_d;
            err_q          <= err_d;
            drive_q        <= drive_d;
            ready_q        <= ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_presence_q <= rsp_presence_d;
            rsp_error_q    <= rsp_error_d;
            bus_out_q      <= bus_out_d;
            sync1_q        <= bus.busIn;
            sync2_q        <= sync1_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
            spu_req_q      <= spu_req_d;
            spu_q          <= spu_d;
`endif
        end
    end

    assign bus.cmdReady    = ready_q;
    assign bus.rspValid    = rsp_valid_q;
    assign bus.rspData     = rsp_data_q;
    assign bus.rspPresence = rsp_presence_q;
    assign bus.rspError    = rsp_error_q;
    assign bus.busOut      = bus_out_q;
`ifdef ONEWIRE_STRONG_PULLUP_EN
    assign bus.strongPullup = spu_q;
`endif

endmodule

// File: tb/tb_onewire_bus_master.sv
// Bench for onewire_bus_master: reactive 1-wire device model, pulse-width monitor,
// and an expected-result model built from the slot/reset timing rules.
module tb_onewire_bus_master;
    localparam int unsigned CH = 3;
    localparam int unsigned CB = 2;
    localparam int unsigned TD = 29;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    onewire_bus_if #(.CHANNELS(CH), .CHANNEL_BITS(CB)) bif ();

    logic [CH-1:0] dev_pull = '0;
    assign bif.busIn = ~(bif.busOut | dev_pull);

    onewire_bus_master #(.CHANNELS(CH), .CHANNEL_BITS(CB), .TICK_DIV(TD)) dut (
        .clock (clk),
        .nReset(rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Device: answers presence after a long low pulse; in slot k with dev_mask[k]
    // set it holds the line low for 25 us from the slot's falling edge.
    logic [CB-1:0] dev_ch      = '0;
    logic [7:0]    dev_mask    = '0;
    bit            dev_present = 1'b0;
    int unsigned   dev_slot    = 0;
    int unsigned   dev_low_t0  = 0;
    int unsigned   pull_from   = 0;
    int unsigned   pull_to     = 0;
    logic          dev_prev    = 1'b0;

    always @(negedge clk) begin
        logic bo;
        bo = bif.busOut[dev_ch];
        if (bo && !dev_prev) begin
            dev_low_t0 = cyc;
            if (dev_slot < 8 && dev_mask[3'(dev_slot)]) begin
                pull_from = cyc;
                pull_to   = cyc + 25 * TD;
            end
            dev_slot++;
        end
        if (!bo && dev_prev && (cyc - dev_low_t0) >= 400 * TD && dev_present) begin
            pull_from = cyc + 30 * TD;
            pull_to   = cyc + 150 * TD;
        end
        dev_prev = bo;
        dev_pull = '0;
        if (cyc >= pull_from && cyc < pull_to) dev_pull[dev_ch] = 1'b1;
    end

    // Monitor: records every busOut low-drive pulse with its channel and width.
    int unsigned   pw_q[$];
    int unsigned   pw_ch_q[$];
    int unsigned   mon_start[CH];
    logic [CH-1:0] mon_prev = '0;

    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (bif.busOut[i] && !mon_prev[i]) mon_start[i] = cyc;
            if (!bif.busOut[i] && mon_prev[i]) begin
                pw_q.push_back(cyc - mon_start[i]);
                pw_ch_q.push_back(i);
            end
        end
        mon_prev = bif.busOut;
    end

    task automatic do_cmd(input logic [1:0] op, input int unsigned ch, input logic [7:0] data,
                          input logic [7:0] mask, input bit present, input bit spu);
        bit          err;
        int unsigned nslot, lat, n, acc, got_lat, npw;
        logic [7:0]  exp_data;
        logic        exp_pres;
        int unsigned exp_pw[$];
        err      = (op == 2'b11) || (ch >= CH);
        nslot    = err ? 0 : (op == 2'b01) ? 1 : (op == 2'b10) ? 8 : 0;
        lat      = err ? 1 : (op == 2'b00) ? 960 * TD + 1 : nslot * 70 * TD + 1;
        exp_data = '0;
        for (int i = 0; i < 8; i++)
            if (i < nslot) exp_data[3'(i)] = data[3'(i)] & ~mask[3'(i)];
        exp_pres = !err && op == 2'b00 && present;
        if (!err && op == 2'b00) exp_pw.push_back(480 * TD);
        for (int i = 0; i < 8; i++)
            if (i < nslot) exp_pw.push_back(data[3'(i)] ? 6 * TD : 60 * TD);

        pw_q.delete();
        pw_ch_q.delete();
        dev_ch      = err ? '0 : CB'(ch);
        dev_mask    = mask;
        dev_present = present;
        dev_slot    = 0;
        pull_to     = 0;

        n = 0;
        while (bif.cmdReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("ready_idle", 32'(bif.cmdReady), 1);
        bif.cmdOp      = op;
        bif.cmdChannel = CB'(ch);
        bif.cmdData    = data;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        bif.cmdStrongPullup = spu;
`endif
        bif.cmdValid = 1'b1;
        @(negedge clk);
        acc          = cyc;
        bif.cmdValid = 1'b0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        bif.cmdStrongPullup = 1'b0;
        check_eq("spu_clear", 32'(bif.strongPullup), 0);
`endif
        check_eq("ready_busy", 32'(bif.cmdReady), 0);

        n = 0;
        while (bif.rspValid !== 1'b1 && n < lat + 100) begin
            @(negedge clk);
            n++;
        end
        got_lat = cyc - acc;
        check_eq("rsp_seen", 32'(bif.rspValid), 1);
        check_eq("latency", got_lat, lat);
        check_eq("rsp_data", 32'(bif.rspData), 32'(exp_data));
        check_eq("rsp_presence", 32'(bif.rspPresence), 32'(exp_pres));
        check_eq("rsp_error", 32'(bif.rspError), 32'(err));
`ifdef ONEWIRE_STRONG_PULLUP_EN
        check_eq("spu_on", 32'(bif.strongPullup),
                 (spu && op == 2'b10 && !err) ? (32'd1 << ch) : 32'd0);
`else
        if (spu) check_eq("spu_unsupported", 32'(bif.rspError), 32'(err));
`endif
        @(negedge clk);
        check_eq("rsp_one_cycle", 32'(bif.rspValid), 0);
        check_eq("ready_after", 32'(bif.cmdReady), 1);
        check_eq("rsp_hold", 32'(bif.rspData), 32'(exp_data));

        check_eq("pulse_count", pw_q.size(), exp_pw.size());
        npw = (pw_q.size() < exp_pw.size()) ? pw_q.size() : exp_pw.size();
        for (int i = 0; i < npw; i++) begin
            check_eq($sformatf("pulse_ch[%0d]", i), pw_ch_q[i], ch);
            check_eq($sformatf("pulse_width[%0d]", i), pw_q[i], exp_pw[i]);
        end
    endtask

    initial begin
        int unsigned seen;
        int unsigned r;
        logic [7:0]  d, m;
        bif.cmdValid   = 1'b0;
        bif.cmdOp      = 2'b00;
        bif.cmdChannel = '0;
        bif.cmdData    = '0;
`ifdef ONEWIRE_STRONG_PULLUP_EN
        bif.cmdStrongPullup = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(bif.cmdReady), 1);
        check_eq("rst_valid", 32'(bif.rspValid), 0);
        check_eq("rst_busout", 32'(bif.busOut), 0);
        check_eq("rst_data", 32'(bif.rspData), 0);
        check_eq("rst_presence", 32'(bif.rspPresence), 0);
        check_eq("rst_error", 32'(bif.rspError), 0);
`ifdef ONEWIRE_STRONG_PULLUP_EN
        check_eq("rst_spu", 32'(bif.strongPullup), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(2'b00, 0, 8'h00, 8'h00, 1'b1, 1'b0);
        do_cmd(2'b10, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
        do_cmd(2'b10, 0, 8'hFF, 8'h0A, 1'b0, 1'b0);
        do_cmd(2'b01, CH, 8'h01, 8'h00, 1'b0, 1'b0);
        do_cmd(2'b11, 0, 8'h5A, 8'h00, 1'b0, 1'b0);

        // Reset asserted while a written-0 slot holds channel 2 low.
        pw_q.delete();
        pw_ch_q.delete();
        dev_mask       = '0;
        dev_present    = 1'b0;
        pull_to        = 0;
        bif.cmdOp      = 2'b01;
        bif.cmdChannel = CB'(2);
        bif.cmdData    = 8'h00;
        bif.cmdValid   = 1'b1;
        @(negedge clk);
        bif.cmdValid = 1'b0;
        repeat (10 * TD) @(negedge clk);
        check_eq("abort_driving", 32'(bif.busOut), 32'b100);
        #2 rst_n = 1'b0;
        #1 check_eq("abort_release", 32'(bif.busOut), 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bif.rspValid) seen = 1;
        end
        rst_n = 1'b1;
        repeat (100 * TD) begin
            @(negedge clk);
            if (bif.rspValid || bif.busOut != '0) seen = 1;
        end
        check_eq("abort_quiet", seen, 0);
        check_eq("abort_ready", 32'(bif.cmdReady), 1);
        do_cmd(2'b01, 2, 8'h01, 8'h00, 1'b0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            r = $urandom_range(0, 3);
            d = 8'($urandom);
            m = 8'($urandom);
            case (r)
                0, 1:    do_cmd(2'b01, $urandom_range(0, CH - 1), d, m, 1'b0, 1'b0);
                2:       do_cmd(2'b11, $urandom_range(0, CH - 1), d, m, 1'b0, 1'b0);
                default: do_cmd(2'($urandom_range(0, 2)), CH, d, m, 1'b0, 1'b0);
            endcase
        end

`ifdef ONEWIRE_STRONG_PULLUP_EN
        do_cmd(2'b10, 1, 8'hCC, 8'h00, 1'b0, 1'b1);
        repeat (50) @(negedge clk);
        check_eq("spu_hold", 32'(bif.strongPullup), 32'b010);
        check_eq("spu_bus_idle", 32'(bif.busOut), 0);
        do_cmd(2'b11, 0, 8'h00, 8'h00, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
